// File: rtl/io_in_debounce.sv
// Input conditioning for the eight registered IO pad bits: two-flop resync, per-channel
// debounce and a show-ahead queue of {channel, level} change events for fabric logic.
module io_in_debounce #(
    parameter int unsigned DBNC_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [0:7]  RESET_LEVEL = 8'h00
) (
    input  logic       IQC,
    input  logic       QRT,
    input  logic [0:7] IQZ,
    output logic [0:7] stable,
    output logic       evt_valid,
    output logic [3:0] evt_data,
    input  logic       evt_ready,
    output logic       overflow,
    input  logic       clr_overflow
);

    localparam int unsigned NCH    = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DW     = 4;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W = PTR_W + 1;

    logic [0:7]        s1_q, s2_q;
    logic [0:7]        stable_q, stable_d;
    logic [CNT_W-1:0]  cnt_q [NCH];
    logic [CNT_W-1:0]  cnt_d [NCH];
    logic [0:7]        pending_q, pending_d;
    logic [0:7]        plev_q, plev_d;
    logic [DW-1:0]     mem_q [FIFO_DEPTH];
    logic [DW-1:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              evt_valid_q, evt_valid_d;
    logic [DW-1:0]     evt_data_q, evt_data_d;
    logic              overflow_q, overflow_d;

    logic [0:7]        accept;
    logic              pop;
    logic              push;
    logic              found;
    logic [2:0]        push_ch;
    logic              ovf_set;

    // Debounce: a level is accepted on its DBNC_CYCLES-th consecutive differing sample.
    always_comb begin
        stable_d = stable_q;
        accept   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DBNC_CYCLES - 1)) begin
                cnt_d[i]    = '0;
                stable_d[i] = s2_q[i];
                accept[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Pending arbitration, event queue and sticky overflow.
    always_comb begin
        pop       = evt_valid_q & evt_ready;
        found     = 1'b0;
        push_ch   = 3'd0;
        pending_d = pending_q;
        plev_d    = plev_q;
        ovf_set   = 1'b0;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fcnt_d    = fcnt_q;

        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found && pending_q[i]) begin
                found   = 1'b1;
                push_ch = 3'(i);
            end
        end
        push = found & ((fcnt_q != FCNT_W'(FIFO_DEPTH)) | pop);

        if (push) begin
            pending_d[push_ch] = 1'b0;
            mem_d[wr_ptr_q]    = {push_ch, plev_q[push_ch]};
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
            2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
            default: fcnt_d = fcnt_q;
        endcase

        // A still-blocked pending entry gets overwritten; the older level is lost.
        for (int unsigned i = 0; i < NCH; i++) begin
            if (accept[i]) begin
                if (pending_d[i]) begin
                    ovf_set = 1'b1;
                end
                pending_d[i] = 1'b1;
                plev_d[i]    = stable_d[i];
            end
        end

        evt_valid_d = (fcnt_d != '0);
        evt_data_d  = evt_valid_d ? mem_d[rd_ptr_d] : evt_data_q;

        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge IQC) begin
        if (!QRT) begin
            s1_q        <= RESET_LEVEL;
            s2_q        <= RESET_LEVEL;
            stable_q    <= RESET_LEVEL;
            cnt_q       <= '{default: '0};
            pending_q   <= '0;
            plev_q      <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            s1_q        <= IQZ;
            s2_q        <= s1_q;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            plev_q      <= plev_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
            evt_valid_q <= evt_valid_d;
            evt_data_q  <= evt_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign stable    = stable_q;
    assign evt_valid = evt_valid_q;
    assign evt_data  = evt_data_q;
    assign overflow  = overflow_q;

endmodule
